// File: rtl/wb_scoreboard_if.sv
// Bundle of issue/retire/squash events and ID-stage source queries for wb_scoreboard.
// The pipeline side drives the events (master); the scoreboard answers (slave).
interface wb_scoreboard_if #(
    parameter int NREGS = 16,
    parameter int RD_W  = 4
);
    // Event semantics: each *_valid / squash_ex pulse is one event in the cycle it is
    // high; there is no ready, and the scoreboard accepts every event unconditionally.
    logic              issue_valid;
    logic              issue_we;
    logic [RD_W-1:0]   issue_rd;
    logic              issue_is_load;
    logic              ldrdy_valid;
    logic [RD_W-1:0]   ldrdy_rd;
    logic              commit_valid;
    logic [RD_W-1:0]   commit_rd;
    logic              squash_ex;
    logic [RD_W-1:0]   squash_ex_rd;
    logic              squash_ex_load;
    logic              squash_ex_we;
    logic [RD_W-1:0]   id_rs1;
    logic [RD_W-1:0]   id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              stall_id;
    logic [NREGS-1:0]  pending_mask;
    logic              busy;
    logic              sb_error;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_is_load,
        output ldrdy_valid, ldrdy_rd, commit_valid, commit_rd,
        output squash_ex, squash_ex_rd, squash_ex_load, squash_ex_we,
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  stall_id, pending_mask, busy, sb_error
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_is_load,
        input  ldrdy_valid, ldrdy_rd, commit_valid, commit_rd,
        input  squash_ex, squash_ex_rd, squash_ex_load, squash_ex_we,
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output stall_id, pending_mask, busy, sb_error
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Per-register counters of in-flight writes and loads for the RV32E pipeline,
// producing the load-use stall for ID and a sticky counter-error flag.
module wb_scoreboard #(
    parameter int NREGS = 16,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    wb_scoreboard_if.slave  bus
);
    localparam int RD_W = $clog2(NREGS);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] write_cnt [NREGS];
    logic [CNT_W-1:0] load_cnt  [NREGS];
    logic [CNT_W-1:0] write_nxt [NREGS];
    logic [CNT_W-1:0] load_nxt  [NREGS];
    logic             sb_error_q;
    logic             err_nxt;

    logic             issue_hit, commit_hit, ldrdy_hit, squash_hit;
    logic [1:0]       w_dec, l_dec;
    logic             w_err, l_err;

    // Returns {error, new_count}: net delta with clamp at 0 and saturation at max.
    function automatic logic [CNT_W:0] apply_delta(input logic [CNT_W-1:0] cnt,
                                                   input logic inc,
                                                   input logic [1:0] dec);
        logic [CNT_W:0] tot;
        logic [CNT_W:0] dcx;
        tot = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
        dcx = {{(CNT_W-1){1'b0}}, dec};
        if (dcx > tot) begin
            return {1'b1, {CNT_W{1'b0}}};
        end
        tot = tot - dcx;
        if (tot > CNT_MAX) begin
            return {1'b1, {CNT_W{1'b1}}};
        end
        return {1'b0, tot[CNT_W-1:0]};
    endfunction

    always_comb begin
        err_nxt    = sb_error_q;
        issue_hit  = 1'b0;
        commit_hit = 1'b0;
        ldrdy_hit  = 1'b0;
        squash_hit = 1'b0;
        w_dec      = 2'd0;
        l_dec      = 2'd0;
        w_err      = 1'b0;
        l_err      = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            write_nxt[r] = write_cnt[r];
            load_nxt[r]  = load_cnt[r];
        end
        // x0 is never tracked, so rd==0 events fall through untouched.
        for (int r = 1; r < NREGS; r++) begin
            issue_hit  = bus.issue_valid & bus.issue_we & (bus.issue_rd == RD_W'(r));
            commit_hit = bus.commit_valid & (bus.commit_rd == RD_W'(r));
            ldrdy_hit  = bus.ldrdy_valid & (bus.ldrdy_rd == RD_W'(r));
            squash_hit = bus.squash_ex & bus.squash_ex_we & (bus.squash_ex_rd == RD_W'(r));
            w_dec = {1'b0, commit_hit} + {1'b0, squash_hit};
            l_dec = {1'b0, ldrdy_hit} + {1'b0, squash_hit & bus.squash_ex_load};
            {w_err, write_nxt[r]} = apply_delta(write_cnt[r], issue_hit, w_dec);
            {l_err, load_nxt[r]}  = apply_delta(load_cnt[r], issue_hit & bus.issue_is_load, l_dec);
            err_nxt = err_nxt | w_err | l_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error_q <= 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                write_cnt[r] <= '0;
                load_cnt[r]  <= '0;
            end
        end else begin
            sb_error_q <= err_nxt;
            for (int r = 0; r < NREGS; r++) begin
                write_cnt[r] <= write_nxt[r];
                load_cnt[r]  <= load_nxt[r];
            end
        end
    end

    // A load that has reached WB is forwardable, so only load_cnt matters here.
    assign bus.stall_id = (bus.id_rs1_used && (bus.id_rs1 != '0) && (load_cnt[bus.id_rs1] != '0)) ||
                          (bus.id_rs2_used && (bus.id_rs2 != '0) && (load_cnt[bus.id_rs2] != '0));

    always_comb begin
        bus.pending_mask = '0;
        for (int r = 1; r < NREGS; r++) begin
            bus.pending_mask[r] = (write_cnt[r] != '0);
        end
    end

    assign bus.busy     = |bus.pending_mask;
    assign bus.sb_error = sb_error_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: a reference model pushes expected
// {stall_id, sb_error, busy, pending_mask} per cycle and each test drains and compares.
module tb_wb_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [18:0] exp_q[$];
  logic [18:0] act_q[$];

  int m_w[16];
  int m_l[16];
  bit m_err;

  wb_scoreboard_if bus ();

  wb_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.issue_valid    = 1'b0;
    bus.issue_we       = 1'b0;
    bus.issue_rd       = 4'd0;
    bus.issue_is_load  = 1'b0;
    bus.ldrdy_valid    = 1'b0;
    bus.ldrdy_rd       = 4'd0;
    bus.commit_valid   = 1'b0;
    bus.commit_rd      = 4'd0;
    bus.squash_ex      = 1'b0;
    bus.squash_ex_rd   = 4'd0;
    bus.squash_ex_load = 1'b0;
    bus.squash_ex_we   = 1'b0;
    bus.id_rs1         = 4'd0;
    bus.id_rs2         = 4'd0;
    bus.id_rs1_used    = 1'b0;
    bus.id_rs2_used    = 1'b0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic is_load);
    bus.issue_valid   = 1'b1;
    bus.issue_we      = 1'b1;
    bus.issue_rd      = rd;
    bus.issue_is_load = is_load;
  endtask

  task automatic no_issue();
    bus.issue_valid   = 1'b0;
    bus.issue_we      = 1'b0;
    bus.issue_is_load = 1'b0;
  endtask

  task automatic model_edge();
    int iw, il, cw, lr, sw, sl, nw, nl;
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        m_w[r] = 0;
        m_l[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      for (int r = 1; r < 16; r++) begin
        iw = (bus.issue_valid && bus.issue_we && bus.issue_rd == r) ? 1 : 0;
        il = (iw == 1 && bus.issue_is_load) ? 1 : 0;
        cw = (bus.commit_valid && bus.commit_rd == r) ? 1 : 0;
        lr = (bus.ldrdy_valid && bus.ldrdy_rd == r) ? 1 : 0;
        sw = (bus.squash_ex && bus.squash_ex_we && bus.squash_ex_rd == r) ? 1 : 0;
        sl = (sw == 1 && bus.squash_ex_load) ? 1 : 0;
        nw = m_w[r] + iw - cw - sw;
        nl = m_l[r] + il - lr - sl;
        if (nw < 0) begin nw = 0; m_err = 1'b1; end
        if (nw > 7) begin nw = 7; m_err = 1'b1; end
        if (nl < 0) begin nl = 0; m_err = 1'b1; end
        if (nl > 7) begin nl = 7; m_err = 1'b1; end
        m_w[r] = nw;
        m_l[r] = nl;
      end
    end
  endtask

  function automatic logic [18:0] model_out();
    logic [15:0] mask;
    logic        stall;
    mask = 16'h0000;
    for (int r = 1; r < 16; r++) mask[r] = (m_w[r] > 0);
    stall = (bus.id_rs1_used && bus.id_rs1 != 0 && m_l[bus.id_rs1] > 0) ||
            (bus.id_rs2_used && bus.id_rs2 != 0 && m_l[bus.id_rs2] > 0);
    return {stall, m_err, (mask != 16'h0000), mask};
  endfunction

  // One clock: model advances on the values present at the edge, outputs sampled 1ns later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    exp_q.push_back(model_out());
    act_q.push_back({bus.stall_id, bus.sb_error, bus.busy, bus.pending_mask});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.issue_valid   = 1'($urandom_range(0, 1));
      bus.issue_we      = 1'($urandom_range(0, 1));
      bus.issue_rd      = 4'($urandom_range(0, 15));
      bus.issue_is_load = 1'($urandom_range(0, 1));
      bus.commit_valid  = 1'($urandom_range(0, 1));
      bus.commit_rd     = 4'($urandom_range(0, 15));
      bus.ldrdy_valid   = 1'($urandom_range(0, 1));
      bus.ldrdy_rd      = 4'($urandom_range(0, 15));
      step();
    end
    idle();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.stall_id, bus.sb_error, bus.busy, bus.pending_mask} !== 19'd0) begin
      $display("FAIL reset_outputs: got %h want 0",
               {bus.stall_id, bus.sb_error, bus.busy, bus.pending_mask});
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL reset_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_load_use();
    idle();
    issue(4'd5, 1'b1);
    bus.id_rs1 = 4'd5; bus.id_rs1_used = 1'b1;
    step();
    no_issue();
    checks++;
    if (bus.stall_id !== 1'b1) begin $display("FAIL load_use_stall: got %b want 1", bus.stall_id); failures++; end
    step(); step();
    checks++;
    if (bus.stall_id !== 1'b1) begin $display("FAIL load_use_held: got %b want 1", bus.stall_id); failures++; end
    bus.ldrdy_valid = 1'b1; bus.ldrdy_rd = 4'd5;
    step();
    bus.ldrdy_valid = 1'b0;
    checks++;
    if (bus.stall_id !== 1'b0 || bus.pending_mask !== 16'h0020) begin
      $display("FAIL load_use_release: got stall=%b mask=%h want 0/0020", bus.stall_id, bus.pending_mask);
      failures++;
    end
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd5;
    step();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.pending_mask[5] !== 1'b0) begin $display("FAIL load_use_commit: got %b want 0", bus.pending_mask[5]); failures++; end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL load_use_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_alu();
    idle();
    issue(4'd3, 1'b0);
    bus.id_rs2 = 4'd3; bus.id_rs2_used = 1'b1;
    step();
    no_issue();
    checks++;
    if (bus.stall_id !== 1'b0 || bus.pending_mask !== 16'h0008 || bus.busy !== 1'b1) begin
      $display("FAIL alu_pending: got stall=%b mask=%h busy=%b want 0/0008/1", bus.stall_id, bus.pending_mask, bus.busy);
      failures++;
    end
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd3;
    step();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.pending_mask !== 16'h0000 || bus.busy !== 1'b0) begin
      $display("FAIL alu_commit: got mask=%h busy=%b want 0000/0", bus.pending_mask, bus.busy);
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL alu_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_back_to_back();
    idle();
    issue(4'd7, 1'b0);
    step();
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd7;
    step();
    no_issue();
    checks++;
    if (bus.pending_mask[7] !== 1'b1 || bus.sb_error !== 1'b0) begin
      $display("FAIL same_cycle_x7: got mask7=%b err=%b want 1/0", bus.pending_mask[7], bus.sb_error);
      failures++;
    end
    step();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.pending_mask[7] !== 1'b0 || bus.sb_error !== 1'b0) begin
      $display("FAIL same_cycle_drain: got mask7=%b err=%b want 0/0", bus.pending_mask[7], bus.sb_error);
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL same_cycle_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_squash();
    idle();
    issue(4'd9, 1'b1);
    bus.id_rs2 = 4'd9; bus.id_rs2_used = 1'b1;
    step();
    no_issue();
    bus.squash_ex = 1'b1; bus.squash_ex_rd = 4'd9; bus.squash_ex_we = 1'b1; bus.squash_ex_load = 1'b1;
    step();
    bus.squash_ex = 1'b0; bus.squash_ex_we = 1'b0; bus.squash_ex_load = 1'b0;
    checks++;
    if (bus.stall_id !== 1'b0 || bus.pending_mask !== 16'h0000 || bus.sb_error !== 1'b0) begin
      $display("FAIL squash_x9: got stall=%b mask=%h err=%b want 0/0000/0", bus.stall_id, bus.pending_mask, bus.sb_error);
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL squash_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_rd_zero();
    idle();
    issue(4'd0, 1'b1);
    bus.id_rs1 = 4'd0; bus.id_rs1_used = 1'b1;
    step();
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd0;
    step();
    no_issue();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.pending_mask !== 16'h0000 || bus.busy !== 1'b0 || bus.stall_id !== 1'b0 || bus.sb_error !== 1'b0) begin
      $display("FAIL rd_zero: got mask=%h busy=%b stall=%b err=%b want all 0",
               bus.pending_mask, bus.busy, bus.stall_id, bus.sb_error);
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL rd_zero_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_overflow();
    idle();
    issue(4'd2, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (bus.sb_error !== 1'b0 || bus.pending_mask[2] !== 1'b1) begin
      $display("FAIL ovf_at_max: got err=%b mask2=%b want 0/1", bus.sb_error, bus.pending_mask[2]);
      failures++;
    end
    step();
    no_issue();
    checks++;
    if (bus.sb_error !== 1'b1) begin $display("FAIL ovf_error: got %b want 1", bus.sb_error); failures++; end
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd2;
    for (int i = 0; i < 7; i++) step();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.pending_mask[2] !== 1'b0 || bus.sb_error !== 1'b1) begin
      $display("FAIL ovf_saturated: got mask2=%b err=%b want 0/1", bus.pending_mask[2], bus.sb_error);
      failures++;
    end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL ovf_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_underflow();
    idle();
    bus.commit_valid = 1'b1; bus.commit_rd = 4'd4;
    step();
    bus.commit_valid = 1'b0;
    checks++;
    if (bus.sb_error !== 1'b1 || bus.pending_mask !== 16'h0000) begin
      $display("FAIL underflow_error: got err=%b mask=%h want 1/0000", bus.sb_error, bus.pending_mask);
      failures++;
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.sb_error !== 1'b1) begin $display("FAIL underflow_sticky: got %b want 1", bus.sb_error); failures++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.sb_error !== 1'b0) begin $display("FAIL underflow_rst_clear: got %b want 0", bus.sb_error); failures++; end
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL underflow_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 300; i++) begin
      bus.issue_valid    = ($urandom_range(0, 2) == 0);
      bus.issue_we       = ($urandom_range(0, 3) != 0);
      bus.issue_rd       = 4'($urandom_range(0, 4));
      bus.issue_is_load  = 1'($urandom_range(0, 1));
      bus.ldrdy_valid    = ($urandom_range(0, 3) == 0);
      bus.ldrdy_rd       = 4'($urandom_range(0, 4));
      bus.commit_valid   = ($urandom_range(0, 2) == 0);
      bus.commit_rd      = 4'($urandom_range(0, 4));
      bus.squash_ex      = ($urandom_range(0, 7) == 0);
      bus.squash_ex_rd   = 4'($urandom_range(0, 4));
      bus.squash_ex_we   = 1'($urandom_range(0, 1));
      bus.squash_ex_load = 1'($urandom_range(0, 1));
      bus.id_rs1         = 4'($urandom_range(0, 4));
      bus.id_rs2         = 4'($urandom_range(0, 4));
      bus.id_rs1_used    = 1'($urandom_range(0, 1));
      bus.id_rs2_used    = 1'($urandom_range(0, 1));
      rst                = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    while (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin $display("FAIL random_sb: got %h want %h", a, e); failures++; end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_err    = 1'b0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu();
    test_back_to_back();
    test_squash();
    test_rd_zero();
    test_overflow();
    test_underflow();
    test_random();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
